// File: rtl/accelerator_content_based_scoring.sv
// accelerator_content_based_scoring: loads key k[0..J-1], streams matrix rows M[i,*] and emits
// one beta-scaled score per row (MODE 0: k.M[i], MODE 1: -sum (k-M[i])^2). Score registered one cycle after the row's last element.
// No back-pressure: one element/cycle; enables outside LOAD_KEY/STREAM_ROW are dropped without acknowledge.
// Ports: CLK/RST (sync, active-low); START/MODE_IN/SIZE_I_IN/SIZE_J_IN/BETA_IN operation setup;
// K_IN*/K_OUT_ENABLE key stream; M_IN*/M_OUT_* matrix stream; C_OUT/C_OUT_ENABLE scores; READY/ERROR completion.
// Optional: define ACCELERATOR_CBA_ARGMAX_EN to add MAX_OUT/INDEX_OUT (largest score and its row).
module accelerator_content_based_scoring #(
  parameter int DATA_SIZE     = 64,
  parameter int CONTROL_SIZE  = 64,
  parameter int FRACTION_SIZE = 16,
  parameter int KEY_DEPTH     = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    ERROR,
  input  logic                    MODE_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
  input  logic [DATA_SIZE-1:0]    BETA_IN,
  input  logic                    K_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    K_IN,
  output logic                    K_OUT_ENABLE,
  input  logic                    M_IN_J_ENABLE,
  input  logic                    M_IN_I_ENABLE,
  input  logic [DATA_SIZE-1:0]    M_IN,
  output logic                    M_OUT_J_ENABLE,
  output logic                    M_OUT_I_ENABLE,
  output logic                    C_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    C_OUT
`ifdef ACCELERATOR_CBA_ARGMAX_EN
  ,
  output logic [DATA_SIZE-1:0]    MAX_OUT,
  output logic [CONTROL_SIZE-1:0] INDEX_OUT
`endif
);

  localparam int KIDX  = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
  localparam int ACC_W = 2*DATA_SIZE + $clog2(KEY_DEPTH);
  localparam int PW    = 2*DATA_SIZE;

  // Saturation bounds of a DATA_SIZE word, sign-extended to the wider arithmetic widths.
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
  localparam logic signed [PW-1:0]    P_MAX   = {{(PW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [PW-1:0]    P_MIN   = {{(PW-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD_KEY, S_STREAM_ROW, S_SCALE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic                     mode_q, mode_d;
  logic [DATA_SIZE-1:0]     size_i_q, size_i_d, size_j_q, size_j_d, beta_q, beta_d;
  logic [CONTROL_SIZE-1:0]  i_q, i_d, j_q, j_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     k_ack_q, k_ack_d, m_ack_q, m_ack_d, row_adv_q, row_adv_d;
  logic                     c_vld_q, c_vld_d, ready_q, ready_d, error_q, error_d;
  logic [DATA_SIZE-1:0]     c_dat_q, c_dat_d;
  logic [DATA_SIZE-1:0]     max_q, max_d;
  logic [CONTROL_SIZE-1:0]  idx_q, idx_d;

  // Key buffer survives reset and operations; every START reloads it.
  logic [DATA_SIZE-1:0]     key_q [KEY_DEPTH];
  logic                     key_we;
  logic [KIDX-1:0]          j_idx;

  logic                     size_bad, last_col, last_row;
  logic signed [ACC_W-1:0]  k_ext, m_ext, diff, prod, acc_nx, sh;
  logic signed [DATA_SIZE-1:0] s_sat;
  logic signed [PW-1:0]     p_full;
  logic [DATA_SIZE-1:0]     c_val;

  logic unused_m_in_i;
  assign unused_m_in_i = M_IN_I_ENABLE;

  assign j_idx    = j_q[KIDX-1:0];
  assign size_bad = (size_j_q == '0) || (size_i_q == '0) || (size_j_q > DATA_SIZE'(KEY_DEPTH));
  assign last_col = (DATA_SIZE'(j_q) == size_j_q - 1'b1);
  assign last_row = (DATA_SIZE'(i_q) == size_i_q - 1'b1);

  // Datapath: full-precision accumulate, then two shift-and-saturate stages.
  always_comb begin
    k_ext  = ACC_W'($signed(key_q[j_idx]));
    m_ext  = ACC_W'($signed(M_IN));
    diff   = k_ext - m_ext;  // fits DATA_SIZE+1 bits
    prod   = mode_q ? diff * diff : k_ext * m_ext;
    acc_nx = mode_q ? acc_q - prod : acc_q + prod;
    sh     = acc_nx >>> FRACTION_SIZE;
    if (sh > ACC_MAX)      s_sat = ACC_MAX[DATA_SIZE-1:0];
    else if (sh < ACC_MIN) s_sat = ACC_MIN[DATA_SIZE-1:0];
    else                   s_sat = sh[DATA_SIZE-1:0];
    p_full = (PW'(s_sat) * PW'($signed(beta_q))) >>> FRACTION_SIZE;
    if (p_full > P_MAX)      c_val = P_MAX[DATA_SIZE-1:0];
    else if (p_full < P_MIN) c_val = P_MIN[DATA_SIZE-1:0];
    else                     c_val = p_full[DATA_SIZE-1:0];
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    size_i_d  = size_i_q;
    size_j_d  = size_j_q;
    beta_d    = beta_q;
    i_d       = i_q;
    j_d       = j_q;
    acc_d     = acc_q;
    c_dat_d   = c_dat_q;
    max_d     = max_q;
    idx_d     = idx_q;
    k_ack_d   = 1'b0;
    m_ack_d   = 1'b0;
    row_adv_d = 1'b0;
    c_vld_d   = 1'b0;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    key_we    = 1'b0;
    unique case (state_q)
      S_IDLE: if (START) begin
        mode_d   = MODE_IN;
        size_i_d = SIZE_I_IN;
        size_j_d = SIZE_J_IN;
        beta_d   = BETA_IN;
        i_d      = '0;
        j_d      = '0;
        max_d    = '0;
        idx_d    = '0;
        state_d  = S_LOAD_KEY;
      end
      S_LOAD_KEY: begin
        if (size_bad) begin
          // Sizes are checked on the first LOAD_KEY cycle, so no key is ever accepted.
          ready_d = 1'b1;
          error_d = 1'b1;
          state_d = S_DONE;
        end else if (K_IN_ENABLE) begin
          key_we  = 1'b1;
          k_ack_d = 1'b1;
          if (last_col) begin
            j_d     = '0;
            acc_d   = '0;
            state_d = S_STREAM_ROW;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_STREAM_ROW: if (M_IN_J_ENABLE) begin
        m_ack_d = 1'b1;
        acc_d   = acc_nx;
        if (last_col) begin
          // Score is computed from the final accumulation and registered at this edge.
          j_d       = '0;
          c_vld_d   = 1'b1;
          c_dat_d   = c_val;
          row_adv_d = !last_row;
          state_d   = S_SCALE;
          if ((i_q == '0) || ($signed(c_val) > $signed(max_q))) begin
            max_d = c_val;
            idx_d = i_q;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      S_SCALE: begin
        acc_d = '0;
        if (last_row) begin
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = S_STREAM_ROW;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (key_we) key_q[j_idx] <= K_IN;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      size_i_q  <= '0;
      size_j_q  <= '0;
      beta_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      acc_q     <= '0;
      c_dat_q   <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      k_ack_q   <= 1'b0;
      m_ack_q   <= 1'b0;
      row_adv_q <= 1'b0;
      c_vld_q   <= 1'b0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      size_i_q  <= size_i_d;
      size_j_q  <= size_j_d;
      beta_q    <= beta_d;
      i_q       <= i_d;
      j_q       <= j_d;
      acc_q     <= acc_d;
      c_dat_q   <= c_dat_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      k_ack_q   <= k_ack_d;
      m_ack_q   <= m_ack_d;
      row_adv_q <= row_adv_d;
      c_vld_q   <= c_vld_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
    end
  end

  assign READY          = ready_q;
  assign ERROR          = error_q;
  assign K_OUT_ENABLE   = k_ack_q;
  assign M_OUT_J_ENABLE = m_ack_q;
  assign M_OUT_I_ENABLE = row_adv_q;
  assign C_OUT_ENABLE   = c_vld_q;
  assign C_OUT          = c_dat_q;

`ifdef ACCELERATOR_CBA_ARGMAX_EN
  assign MAX_OUT   = max_q;
  assign INDEX_OUT = idx_q;
`else
  logic unused_argmax;
  assign unused_argmax = ^{max_q, idx_q};
`endif

endmodule

// File: doc/accelerator_content_based_scoring.md
# accelerator_content_based_scoring

Parametrised content-scoring engine for the DNC memory path: loads a key vector k[0..J-1] into an internal buffer, then streams the memory matrix M row by row and emits one beta-sharpened similarity score per row. Two modes are supported: dot product k·M[i,·] and negated squared L2 distance −Σ(k−M[i,·])². The scores feed the downstream exponentiator/softmax stage of content-based addressing.

## Interface
- DATA_SIZE, 64, word width; signed two's-complement fixed point
- CONTROL_SIZE, 64, width of internal counters
- FRACTION_SIZE, 16, number of fractional bits (Q(DATA_SIZE−FRACTION_SIZE).FRACTION_SIZE)
- KEY_DEPTH, 64, maximum J held in the key buffer
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  reset, synchronous, active-low
- START  in  1  begin an operation (sampled in IDLE only)
- READY  out  1  one-cycle pulse when the operation ends
- ERROR  out  1  one-cycle pulse, together with READY, on illegal size
- MODE_IN  in  1  0 = dot product, 1 = negated squared distance
- SIZE_I_IN, SIZE_J_IN  in  DATA_SIZE  row count I and row length J
- BETA_IN  in  DATA_SIZE  key strength beta
- K_IN_ENABLE  in  1  K_IN valid
- K_IN  in  DATA_SIZE  key element
- K_OUT_ENABLE  out  1  acknowledges an accepted key element
- M_IN_J_ENABLE  in  1  M_IN valid
- M_IN_I_ENABLE  in  1  unused; must tie to 0
- M_IN  in  DATA_SIZE  matrix element, row-major
- M_OUT_J_ENABLE  out  1  acknowledges an accepted matrix element
- M_OUT_I_ENABLE  out  1  pulse; the next row may start
- C_OUT_ENABLE  out  1  C_OUT valid, one cycle per row
- C_OUT  out  DATA_SIZE  score of row i

## Operation
- States: IDLE, LOAD_KEY, STREAM_ROW, SCALE, DONE.
- IDLE + START=1 latches SIZE_I_IN, SIZE_J_IN, BETA_IN and MODE_IN. The state then goes to LOAD_KEY.
- If I=0, J=0 or J>KEY_DEPTH, the block goes to DONE with ERROR=1. No K or M element is accepted.
- LOAD_KEY: each cycle with K_IN_ENABLE=1 stores K_IN at index j and pulses K_OUT_ENABLE in the next cycle. After J elements the state goes to STREAM_ROW with the accumulator cleared.
- STREAM_ROW: each M_IN_J_ENABLE=1 cycle accepts M_IN as column j and pulses M_OUT_J_ENABLE in the next cycle.
  - Mode 0: acc += k[j]·M_IN.
  - Mode 1: acc −= (k[j]−M_IN)².
- After column J−1 the state goes to SCALE.
- Arithmetic:
  - Products and the accumulator are full precision: 2·DATA_SIZE+clog2(KEY_DEPTH) bits.
  - Mode 1 uses a DATA_SIZE+1-bit difference.
  - At row end: s = acc >>> FRACTION_SIZE (arithmetic shift), saturated to DATA_SIZE.
  - Then C_OUT = sat((s·beta) >>> FRACTION_SIZE).
  - Saturation clamps to the most positive or most negative DATA_SIZE value.
- SCALE: registers C_OUT and pulses C_OUT_ENABLE.
  - If i<I−1: pulses M_OUT_I_ENABLE, clears the accumulator, returns to STREAM_ROW.
  - Otherwise goes to DONE.
- M_IN_J_ENABLE asserted outside STREAM_ROW is dropped, with no acknowledge. The same applies to K_IN_ENABLE outside LOAD_KEY.
- DONE: pulses READY (with ERROR if applicable), then returns to IDLE.
- START asserted outside IDLE is ignored.
- The key buffer is retained across operations but reloaded on every START. It is not cleared by reset.

## Timing
- Reset (RST=0 at a rising edge) forces IDLE, takes effect mid-operation, and discards partial results. All outputs go to 0: READY, ERROR, K_OUT_ENABLE, M_OUT_J_ENABLE, M_OUT_I_ENABLE, C_OUT_ENABLE, C_OUT.
- START sampled at edge t: LOAD_KEY from t+1. The first K element can be accepted at t+1.
- The block accepts one element per cycle; there is no back-pressure inside LOAD_KEY or STREAM_ROW.
- Last element of row i accepted at edge t:
  - C_OUT_ENABLE=1 and C_OUT valid during cycle t+1 (SCALE, then registered).
  - M_OUT_I_ENABLE in the same cycle.
  - The next row's first element is accepted from edge t+2.
- Last row: READY=1 during the cycle after the final C_OUT_ENABLE.
- C_OUT holds its value between pulses.
- Illegal size: READY=ERROR=1 two cycles after START.
- Minimum operation length: 1 + J + I·(J+1) + 1 cycles.

## Configuration
- ACCELERATOR_CBA_ARGMAX_EN defined:
  - Adds outputs MAX_OUT (DATA_SIZE) and INDEX_OUT (CONTROL_SIZE), both valid while READY=1 and held until the next START.
  - MAX_OUT is the largest C_OUT of the operation. INDEX_OUT is its row; ties keep the lowest index.
  - On ERROR both are 0. Both reset to 0.
  - MAX_OUT serves the downstream softmax for max-subtraction.
- Undefined: ports and tracking logic are absent; all other behaviour is identical.

## Test plan
- Mode 0, FRACTION_SIZE=16, J=3, I=2, beta=1.0 (65536):
  - Stimulus: k=(1,2,3), rows (1,1,1) and (−1,0,2) in Q.16.
  - Response: C_OUT=6.0 then 5.0; READY one cycle after the second C_OUT_ENABLE.
- Mode 1, same key, beta=2.0:
  - Stimulus: row (1,2,3), then row (0,2,3).
  - Response: C_OUT=0 then −2.0.
- Saturation: DATA_SIZE=16, FRACTION_SIZE=0, J=1, k=32767, M=32767, beta=1 -> C_OUT=32767. With k=−32768 -> C_OUT=−32768.
- Illegal size:
  - SIZE_J_IN=0 -> READY=ERROR=1 at START+2, no K_OUT_ENABLE.
  - SIZE_J_IN=KEY_DEPTH+1 -> same response.
- Reset mid-row: RST=0 after 2 of 3 elements of row 0 -> all outputs 0 next cycle; a fresh START yields correct scores.
- ACCELERATOR_CBA_ARGMAX_EN, I=3:
  - Stimulus: scores 4, 9, 9.
  - Response: MAX_OUT=9 and INDEX_OUT=1 with READY.
  - Dropped M_IN_J_ENABLE pulses during SCALE do not change the result.
